// File: rtl/rifl_err_pkg.sv
// Shared types for the RIFL error-apply block: mode encoding, FSM states
// and the width of the protected sync header.
package rifl_err_pkg;

  typedef enum logic [1:0] {
    ERR_MODE_OFF     = 2'd0,
    ERR_MODE_CONT    = 2'd1,
    ERR_MODE_ONESHOT = 2'd2
  } err_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ARMED = 2'd2,
    ST_DONE  = 2'd3
  } err_state_e;

  // Sync-header bits at the top of the data word.
  localparam int HDR_BITS = 2;

endpackage

// File: rtl/rifl_popcount.sv
// Combinational population count of a DWIDTH-bit vector.
module rifl_popcount #(
  parameter int DWIDTH = 64,
  parameter int CW     = $clog2(DWIDTH + 1)
) (
  input  logic [DWIDTH-1:0] vec_i,
  output logic [CW-1:0]     cnt_o
);

  // Sum of all set bits; synthesis balances this into an adder tree.
  always_comb begin
    cnt_o = {CW{1'b0}};
    for (int i = 0; i < DWIDTH; i++) begin
      cnt_o = cnt_o + {{(CW-1){1'b0}}, vec_i[i]};
    end
  end

endmodule

// File: rtl/rifl_err_apply.sv
// Applies the injector's per-cycle flip mask to an AXI-Stream beat through
// a one-beat register slice, with off / continuous / armed single-shot
// modes and saturating flip statistics.
// Optional build macro: RIFL_ERR_HDR_PROTECT_EN keeps the top HDR_BITS
// (sync header) of every beat out of the mask and the counters.
module rifl_err_apply
  import rifl_err_pkg::*;
#(
  parameter int DWIDTH    = 64,
  parameter int CNT_WIDTH = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic                 arm,
  input  logic                 cnt_clr,
  input  logic [DWIDTH-1:0]    err_vec,
  input  logic [DWIDTH-1:0]    s_axis_tdata,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [DWIDTH-1:0]    m_axis_tdata,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [CNT_WIDTH-1:0] flip_cnt,
  output logic [CNT_WIDTH-1:0] err_beat_cnt,
  output logic                 oneshot_done
);

  localparam int PW = $clog2(DWIDTH + 1);
  // Sum width wide enough for either operand plus a carry out.
  localparam int SW = ((CNT_WIDTH > PW) ? CNT_WIDTH : PW) + 1;

  err_state_e           state_q;
  logic                 done_q;
  logic [DWIDTH-1:0]    tdata_q, tdata_d;
  logic                 tlast_q, tlast_d;
  logic                 tvalid_q, tvalid_d;
  logic [CNT_WIDTH-1:0] flip_q, flip_d;
  logic [CNT_WIDTH-1:0] beat_q, beat_d;

  logic                 accept_s;
  logic [DWIDTH-1:0]    err_m_s;
  logic [DWIDTH-1:0]    lsb_s;
  logic [DWIDTH-1:0]    eff_mask_s;
  logic [PW-1:0]        pop_s;
  logic [SW-1:0]        flip_sum_s;

  assign s_axis_tready = ~tvalid_q | m_axis_tready;
  assign accept_s      = s_axis_tvalid & s_axis_tready;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign flip_cnt      = flip_q;
  assign err_beat_cnt  = beat_q;
  assign oneshot_done  = done_q;

  // Eligible flip bits: optionally strip the sync header, then isolate the lowest set bit.
  always_comb begin
    err_m_s = err_vec;
`ifdef RIFL_ERR_HDR_PROTECT_EN
    err_m_s[DWIDTH-1 -: HDR_BITS] = {HDR_BITS{1'b0}};
`endif
    lsb_s = err_m_s & (~err_m_s + {{(DWIDTH-1){1'b0}}, 1'b1});
  end

  // Effective mask for the beat being accepted this cycle; zero otherwise.
  always_comb begin
    eff_mask_s = {DWIDTH{1'b0}};
    case (state_q)
      ST_RUN: begin
        if (accept_s) eff_mask_s = err_m_s;
        else          eff_mask_s = {DWIDTH{1'b0}};
      end
      ST_ARMED: begin
        if (accept_s) eff_mask_s = lsb_s;
        else          eff_mask_s = {DWIDTH{1'b0}};
      end
      default: eff_mask_s = {DWIDTH{1'b0}};
    endcase
  end

  rifl_popcount #(.DWIDTH(DWIDTH), .CW(PW)) u_popcount (
    .vec_i (eff_mask_s),
    .cnt_o (pop_s)
  );

  // Register-slice next state: load on accept, drain when the sink takes the beat.
  always_comb begin
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    if (accept_s) begin
      tdata_d  = s_axis_tdata ^ eff_mask_s;
      tlast_d  = s_axis_tlast;
      tvalid_d = 1'b1;
    end else if (m_axis_tready) begin
      tvalid_d = 1'b0;
    end else begin
      tvalid_d = tvalid_q;
    end
  end

  // Saturating counter next state; a clear wins over a same-cycle increment.
  always_comb begin
    flip_sum_s = {{(SW-CNT_WIDTH){1'b0}}, flip_q} + {{(SW-PW){1'b0}}, pop_s};
    flip_d     = flip_q;
    beat_d     = beat_q;
    if (cnt_clr) begin
      flip_d = {CNT_WIDTH{1'b0}};
      beat_d = {CNT_WIDTH{1'b0}};
    end else if (accept_s) begin
      if (|flip_sum_s[SW-1:CNT_WIDTH]) flip_d = {CNT_WIDTH{1'b1}};
      else                             flip_d = flip_sum_s[CNT_WIDTH-1:0];
      if ((|eff_mask_s) && !(&beat_q)) beat_d = beat_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      else                             beat_d = beat_q;
    end else begin
      flip_d = flip_q;
      beat_d = beat_q;
    end
  end

  // Datapath and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tdata_q  <= {DWIDTH{1'b0}};
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
      flip_q   <= {CNT_WIDTH{1'b0}};
      beat_q   <= {CNT_WIDTH{1'b0}};
    end else begin
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
      flip_q   <= flip_d;
      beat_q   <= beat_d;
    end
  end

  // Injection mode FSM with registered oneshot_done; a mode change beats arm.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (mode == ERR_MODE_CONT)                 state_q <= ST_RUN;
          else if ((mode == ERR_MODE_ONESHOT) && arm) state_q <= ST_ARMED;
          else                                       state_q <= ST_IDLE;
        end
        ST_RUN: begin
          done_q <= 1'b0;
          if (mode != ERR_MODE_CONT) state_q <= ST_IDLE;
          else                       state_q <= ST_RUN;
        end
        ST_ARMED: begin
          if (mode != ERR_MODE_ONESHOT) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end else if (accept_s && (|err_m_s)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_ARMED;
            done_q  <= 1'b0;
          end
        end
        ST_DONE: begin
          if (mode != ERR_MODE_ONESHOT) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end else if (arm) begin
            state_q <= ST_ARMED;
            done_q  <= 1'b0;
          end else begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rifl_err_apply.sv
// Directed self-checking bench for rifl_err_apply. A second instance with
// 4-bit counters shares all inputs to exercise counter saturation.
module tb_rifl_err_apply;

`ifdef RIFL_ERR_HDR_PROTECT_EN
  localparam logic [63:0] KEEP = 64'h3FFF_FFFF_FFFF_FFFF;
  localparam int          PB   = 62;
`else
  localparam logic [63:0] KEEP = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam int          PB   = 64;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        arm;
  logic        cnt_clr;
  logic [63:0] err_vec;
  logic [63:0] s_data;
  logic        s_last;
  logic        s_valid;
  logic        s_rdy;
  logic [63:0] m_data;
  logic        m_last;
  logic        m_valid;
  logic        m_rdy;
  logic [47:0] flip;
  logic [47:0] beats;
  logic        done;

  logic        s_rdy4;
  logic [63:0] m_data4;
  logic        m_last4;
  logic        m_valid4;
  logic [3:0]  flip4;
  logic [3:0]  beats4;
  logic        done4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rifl_err_apply #(.DWIDTH(64), .CNT_WIDTH(48)) dut (
    .clk(clk), .rst(rst), .mode(mode), .arm(arm), .cnt_clr(cnt_clr),
    .err_vec(err_vec), .s_axis_tdata(s_data), .s_axis_tlast(s_last),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_rdy), .m_axis_tdata(m_data),
    .m_axis_tlast(m_last), .m_axis_tvalid(m_valid), .m_axis_tready(m_rdy),
    .flip_cnt(flip), .err_beat_cnt(beats), .oneshot_done(done)
  );

  rifl_err_apply #(.DWIDTH(64), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .mode(mode), .arm(arm), .cnt_clr(cnt_clr),
    .err_vec(err_vec), .s_axis_tdata(s_data), .s_axis_tlast(s_last),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_rdy4), .m_axis_tdata(m_data4),
    .m_axis_tlast(m_last4), .m_axis_tvalid(m_valid4), .m_axis_tready(m_rdy),
    .flip_cnt(flip4), .err_beat_cnt(beats4), .oneshot_done(done4)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] exp_q[$];
  logic        exp_l[$];
  int          idx;
  int          nout;
  logic        prev_stall;
  logic [63:0] held_d;
  logic        held_l;

  initial begin
    rst = 1'b1; mode = 2'd0; arm = 1'b0; cnt_clr = 1'b0; err_vec = 64'd0;
    s_data = 64'd0; s_last = 1'b0; s_valid = 1'b0; m_rdy = 1'b1;
    step(); step();
    check_val("rst_m_valid", {63'd0, m_valid}, 64'd0);
    check_val("rst_m_data", m_data, 64'd0);
    check_val("rst_m_last", {63'd0, m_last}, 64'd0);
    check_val("rst_flip", {16'd0, flip}, 64'd0);
    check_val("rst_beats", {16'd0, beats}, 64'd0);
    check_val("rst_done", {63'd0, done}, 64'd0);
    rst = 1'b0;
    #1;
    check_val("rst_s_ready", {63'd0, s_rdy}, 64'd1);

    // OFF: all-ones err_vec must not touch the data.
    err_vec = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1; s_data = 64'hA5A5_A5A5_A5A5_A5A5; s_last = (i == 7);
      step();
      check_val("off_data", m_data, 64'hA5A5_A5A5_A5A5_A5A5);
      check_val("off_valid", {63'd0, m_valid}, 64'd1);
      check_val("off_last", {63'd0, m_last}, (i == 7) ? 64'd1 : 64'd0);
    end
    s_valid = 1'b0; s_last = 1'b0;
    step();
    check_val("off_drain", {63'd0, m_valid}, 64'd0);
    check_val("off_flip", {16'd0, flip}, 64'd0);

    // CONTINUOUS: constant 2-bit mask on zero data.
    mode = 2'd1; err_vec = 64'h3;
    step();
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 64'd0;
      step();
      check_val("cont_data", m_data, 64'h3);
    end
    s_valid = 1'b0;
    step();
    check_val("cont_flip", {16'd0, flip}, 64'd8);
    check_val("cont_beats", {16'd0, beats}, 64'd4);
    check_val("cont_flip4", {60'd0, flip4}, 64'd8);
    check_val("cont_beats4", {60'd0, beats4}, 64'd4);

    // ONESHOT: clear counters, arm, then zero / 0x50 / 0x50 masks.
    mode = 2'd2; cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check_val("clr_flip", {16'd0, flip}, 64'd0);
    arm = 1'b1;
    step();
    arm = 1'b0;
    s_valid = 1'b1; s_data = 64'h1111; err_vec = 64'h0;
    step();
    check_val("os_beat1", m_data, 64'h1111);
    check_val("os_done_pre", {63'd0, done}, 64'd0);
    s_data = 64'h2222; err_vec = 64'h50;
    step();
    check_val("os_beat2", m_data, 64'h2232);
    check_val("os_done", {63'd0, done}, 64'd1);
    s_data = 64'h3333; err_vec = 64'h50;
    step();
    check_val("os_beat3", m_data, 64'h3333);
    s_valid = 1'b0;
    step();
    check_val("os_flip", {16'd0, flip}, 64'd1);
    check_val("os_beats", {16'd0, beats}, 64'd1);
    arm = 1'b1;
    step();
    arm = 1'b0;
    check_val("os_rearm_done", {63'd0, done}, 64'd0);

    // CONTINUOUS with a 5-cycle sink stall mid-stream.
    mode = 2'd1; err_vec = 64'hF;
    step(); step();
    idx = 0; nout = 0; prev_stall = 1'b0;
    for (int c = 0; c < 30; c++) begin
      m_rdy   = !(c >= 4 && c < 9);
      s_valid = (idx < 6);
      s_data  = 64'h1000 + 64'(idx);
      s_last  = (idx == 3 || idx == 5);
      #1;
      if (m_valid && !m_rdy) begin
        check_val("stall_s_ready", {63'd0, s_rdy}, 64'd0);
        if (prev_stall) begin
          check_val("stall_data", m_data, held_d);
          check_val("stall_last", {63'd0, m_last}, {63'd0, held_l});
        end
        prev_stall = 1'b1; held_d = m_data; held_l = m_last;
      end else begin
        prev_stall = 1'b0;
      end
      if (m_valid && m_rdy) begin
        check_val("stream_have_exp", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          check_val("stream_data", m_data, exp_q.pop_front());
          check_val("stream_last", {63'd0, m_last}, {63'd0, exp_l.pop_front()});
        end
        nout++;
      end
      if (s_valid && s_rdy) begin
        exp_q.push_back(s_data ^ 64'hF);
        exp_l.push_back(s_last);
        idx++;
      end
      step();
    end
    m_rdy = 1'b1; s_valid = 1'b0; s_last = 1'b0;
    check_val("stream_nout", 64'(nout), 64'd6);
    check_val("stream_nin", 64'(idx), 64'd6);
    check_val("stream_flip", {16'd0, flip}, 64'd25);
    check_val("stream_flip4_sat", {60'd0, flip4}, 64'hF);

    // All-ones mask: per-beat flips and saturation of the 4-bit counters.
    err_vec = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 12; i++) begin
      s_valid = 1'b1; s_data = 64'd0;
      step();
      check_val("ones_data", m_data, KEEP);
    end
    s_valid = 1'b0;
    step();
    check_val("ones_flip", {16'd0, flip}, 64'(25 + 12 * PB));
    check_val("ones_beats", {16'd0, beats}, 64'd19);
    check_val("sat_flip4", {60'd0, flip4}, 64'hF);
    check_val("sat_beats4", {60'd0, beats4}, 64'hF);

    // Clear coinciding with an accept.
    s_valid = 1'b1; s_data = 64'd0; cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0; s_valid = 1'b0;
    check_val("clracc_data", m_data, KEEP);
    check_val("clracc_flip", {16'd0, flip}, 64'd0);
    check_val("clracc_beats", {16'd0, beats}, 64'd0);
    check_val("clracc_flip4", {60'd0, flip4}, 64'd0);
    check_val("clracc_beats4", {60'd0, beats4}, 64'd0);

    // Reset mid-stream: output dropped, FSM back to IDLE.
    s_valid = 1'b1; s_data = 64'h5555;
    step();
    check_val("pre_rst_data", m_data, 64'h5555 ^ KEEP);
    rst = 1'b1;
    step();
    check_val("midrst_valid", {63'd0, m_valid}, 64'd0);
    check_val("midrst_flip", {16'd0, flip}, 64'd0);
    rst = 1'b0;
    step();
    check_val("post_rst_idle_data", m_data, 64'h5555);
    step();
    check_val("post_rst_run_data", m_data, 64'h5555 ^ KEEP);

    // Reserved mode 3 behaves as OFF.
    s_valid = 1'b0; mode = 2'd3;
    step(); step();
    s_valid = 1'b1; s_data = 64'h5555;
    step();
    s_valid = 1'b0;
    check_val("mode3_data", m_data, 64'h5555);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
